// File: rtl/spi_txn_sequencer.sv
// Command queue and transaction sequencer in front of the SPI master.
// Buffers host commands, launches one master transaction at a time, and
// returns the captured MISO data (or a start-timeout error) in command order.
module spi_txn_sequencer #(
  parameter int SLAVE_COUNT   = 4,
  parameter int CMD_DEPTH     = 4,
  parameter int RSP_DEPTH     = 4,
  parameter int START_TIMEOUT = 64,
  localparam int AW = (SLAVE_COUNT > 1) ? $clog2(SLAVE_COUNT) : 1
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  // host command side
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_addr,
  input  logic [1:0]    cmd_len,
  input  logic [1:0]    cmd_mode,
  input  logic [31:0]   cmd_data,
  // host response side
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_data,
  output logic [AW-1:0] rsp_addr,
  output logic          rsp_err,
  // SPI master side
  output logic          txn_en,
  output logic [1:0]    txn_len,
  output logic [1:0]    spi_mode,
  output logic [AW-1:0] s_addr,
  output logic [31:0]   tx_data_m,
  input  logic          busy_m,
  input  logic [31:0]   rx_data_m,
  output logic          idle
);

  localparam int CPW = $clog2(CMD_DEPTH);
  localparam int RPW = $clog2(RSP_DEPTH);
  localparam int TW  = $clog2(START_TIMEOUT + 1);
  localparam int CEW = AW + 36;  // {addr, len, mode, data}
  localparam int REW = AW + 33;  // {data, addr, err}

  localparam logic [CPW:0]  CMD_FULL = (CPW+1)'(CMD_DEPTH);
  localparam logic [RPW:0]  RSP_FULL = (RPW+1)'(RSP_DEPTH);
  localparam logic [TW-1:0] TO_LAST  = TW'(START_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, ACTIVE, CAPTURE} state_t;

  state_t r_state, w_nstate;

  // ---------------- command FIFO ----------------
  logic [CEW-1:0] r_cmd_mem [CMD_DEPTH];
  logic [CPW-1:0] r_cmd_wp, r_cmd_rp;
  logic [CPW:0]   r_cmd_cnt;
  logic           w_cmd_push, w_cmd_pop, w_cmd_empty;
  logic [CEW-1:0] w_cmd_head;

  assign cmd_ready   = (r_cmd_cnt != CMD_FULL);
  assign w_cmd_empty = (r_cmd_cnt == '0);
  assign w_cmd_push  = cmd_valid & cmd_ready;
  assign w_cmd_head  = r_cmd_mem[r_cmd_rp];

  // Command storage; contents need no reset since the count gates reads.
  always_ff @(posedge sys_clk) begin
    if (w_cmd_push) r_cmd_mem[r_cmd_wp] <= {cmd_addr, cmd_len, cmd_mode, cmd_data};
  end

  // Command pointers and occupancy; depth is a power of 2 so pointers wrap.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_wp  <= '0;
      r_cmd_rp  <= '0;
      r_cmd_cnt <= '0;
    end else begin
      if (w_cmd_push) r_cmd_wp <= r_cmd_wp + 1'b1;
      if (w_cmd_pop)  r_cmd_rp <= r_cmd_rp + 1'b1;
      if (w_cmd_push && !w_cmd_pop)      r_cmd_cnt <= r_cmd_cnt + 1'b1;
      else if (!w_cmd_push && w_cmd_pop) r_cmd_cnt <= r_cmd_cnt - 1'b1;
    end
  end

  // ---------------- response FIFO (first-word-fall-through) ----------------
  logic [REW-1:0] r_rsp_mem [RSP_DEPTH];
  logic [RPW-1:0] r_rsp_wp, r_rsp_rp;
  logic [RPW:0]   r_rsp_cnt;
  logic           w_rsp_push, w_rsp_wr, w_rsp_pop, w_rsp_full;
  logic [REW-1:0] w_rsp_din, w_rsp_head;

  assign w_rsp_full = (r_rsp_cnt == RSP_FULL);
  assign rsp_valid  = (r_rsp_cnt != '0);
  assign w_rsp_pop  = rsp_valid & rsp_ready;
  // Slot reservation at launch means a push never meets a full FIFO;
  // the gate only keeps the FIFO self-consistent.
  assign w_rsp_wr   = w_rsp_push & (!w_rsp_full | w_rsp_pop);
  assign w_rsp_head = r_rsp_mem[r_rsp_rp];
  assign rsp_data   = rsp_valid ? w_rsp_head[REW-1 -: 32] : '0;
  assign rsp_addr   = rsp_valid ? w_rsp_head[AW:1]        : '0;
  assign rsp_err    = rsp_valid & w_rsp_head[0];

  // Response storage.
  always_ff @(posedge sys_clk) begin
    if (w_rsp_wr) r_rsp_mem[r_rsp_wp] <= w_rsp_din;
  end

  // Response pointers and occupancy.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_wp  <= '0;
      r_rsp_rp  <= '0;
      r_rsp_cnt <= '0;
    end else begin
      if (w_rsp_wr)  r_rsp_wp <= r_rsp_wp + 1'b1;
      if (w_rsp_pop) r_rsp_rp <= r_rsp_rp + 1'b1;
      if (w_rsp_wr && !w_rsp_pop)      r_rsp_cnt <= r_rsp_cnt + 1'b1;
      else if (!w_rsp_wr && w_rsp_pop) r_rsp_cnt <= r_rsp_cnt - 1'b1;
    end
  end

  // ---------------- sequencer FSM ----------------
  logic [TW-1:0] r_cnt, w_cnt_nxt;
  logic          r_busy_q;
  logic [1:0]    r_txn_len, r_spi_mode;
  logic [AW-1:0] r_s_addr;
  logic [31:0]   r_tx_data;

  // State, start-timeout counter and busy_m history for edge detection.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_busy_q <= 1'b0;
    end else begin
      r_state  <= w_nstate;
      r_cnt    <= w_cnt_nxt;
      r_busy_q <= busy_m;
    end
  end

  // Latch the popped command; fields stay stable until the next launch.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_txn_len  <= '0;
      r_spi_mode <= '0;
      r_s_addr   <= '0;
      r_tx_data  <= '0;
    end else if (w_cmd_pop) begin
      {r_s_addr, r_txn_len, r_spi_mode, r_tx_data} <= w_cmd_head;
    end
  end

  // Next-state, FIFO pop/push and counter control.
  always_comb begin
    w_nstate   = r_state;
    w_cnt_nxt  = r_cnt;
    w_cmd_pop  = 1'b0;
    w_rsp_push = 1'b0;
    w_rsp_din  = '0;
    case (r_state)
      IDLE: begin
        // A pop in this same cycle is deliberately not counted as a free slot.
        if (!w_cmd_empty && !w_rsp_full) begin
          w_nstate  = LAUNCH;
          w_cmd_pop = 1'b1;
          w_cnt_nxt = '0;
        end
      end
      LAUNCH: begin
        if (busy_m) begin
          w_nstate  = ACTIVE;
          w_cnt_nxt = '0;
        end else if (r_cnt == TO_LAST) begin
          w_nstate   = IDLE;
          w_cnt_nxt  = '0;
          w_rsp_push = 1'b1;
          w_rsp_din  = {32'd0, r_s_addr, 1'b1};
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ACTIVE: begin
        if (r_busy_q && !busy_m) w_nstate = CAPTURE;
      end
      CAPTURE: begin
        w_nstate   = IDLE;
        w_rsp_push = 1'b1;
        w_rsp_din  = {rx_data_m, r_s_addr, 1'b0};
      end
      default: w_nstate = IDLE;
    endcase
  end

  // Derived from registered state so reset drops txn_en immediately.
  assign txn_en    = (r_state == LAUNCH);
  assign txn_len   = r_txn_len;
  assign spi_mode  = r_spi_mode;
  assign s_addr    = r_s_addr;
  assign tx_data_m = r_tx_data;
  assign idle      = (r_state == IDLE) & w_cmd_empty & !rsp_valid;

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Directed bench for spi_txn_sequencer with a simple SPI master model.
module tb_spi_txn_sequencer;
  localparam int AW = 2;
  localparam int RSP_DEPTH = 4;
  localparam int START_TIMEOUT = 64;

  logic          sys_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [1:0]    cmd_len = '0, cmd_mode = '0;
  logic [31:0]   cmd_data = '0;
  logic          rsp_valid, rsp_ready = 1'b0;
  logic [31:0]   rsp_data;
  logic [AW-1:0] rsp_addr;
  logic          rsp_err;
  logic          txn_en;
  logic [1:0]    txn_len, spi_mode;
  logic [AW-1:0] s_addr;
  logic [31:0]   tx_data_m;
  logic          busy_m = 1'b0;
  logic [31:0]   rx_data_m = '0;
  logic          idle;

  int tests = 0;
  int fails = 0;

  spi_txn_sequencer #(.SLAVE_COUNT(4), .CMD_DEPTH(4), .RSP_DEPTH(RSP_DEPTH),
                      .START_TIMEOUT(START_TIMEOUT)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_mode(cmd_mode), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_addr(rsp_addr), .rsp_err(rsp_err),
    .txn_en(txn_en), .txn_len(txn_len), .spi_mode(spi_mode), .s_addr(s_addr),
    .tx_data_m(tx_data_m), .busy_m(busy_m), .rx_data_m(rx_data_m), .idle(idle)
  );

  always #5 sys_clk = ~sys_clk;

  // Response FIFO must never be pushed while full (and not being popped).
  always @(posedge sys_clk) begin
    if (rst_n && dut.w_rsp_push && dut.r_rsp_cnt == 3'(RSP_DEPTH) && !(rsp_valid && rsp_ready)) begin
      fails++;
      $error("FAIL rsp_overflow: push while full");
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_cmd(input logic [1:0] a, input logic [1:0] l, input logic [1:0] m,
                          input logic [31:0] d);
    int n = 0;
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = l; cmd_mode = m; cmd_data = d;
    while (!cmd_ready && n < 500) begin @(negedge sys_clk); n++; end
    @(negedge sys_clk);
    if (n >= 500) chk("push_timeout", 32'(n), 0);
    cmd_valid = 1'b0;
  endtask

  // Master model: waits for txn_en, holds it off 2 cycles, runs busy_m for 4 cycles.
  task automatic serve(input logic [1:0] a, input logic [1:0] l, input logic [1:0] m,
                       input logic [31:0] d, input logic [31:0] rx);
    int n = 0;
    logic [31:0] fexp;
    fexp = {26'd0, l, m, a};
    while (!txn_en && n < 200) begin @(negedge sys_clk); n++; end
    chk("launch_seen", 32'(txn_en), 1);
    chk("launch_fields", {26'd0, txn_len, spi_mode, s_addr}, fexp);
    chk("launch_data", tx_data_m, d);
    repeat (2) @(negedge sys_clk);
    chk("txn_en_held", 32'(txn_en), 1);
    busy_m = 1'b1;
    @(negedge sys_clk);
    chk("txn_en_drop", 32'(txn_en), 0);
    repeat (3) @(negedge sys_clk);
    chk("active_fields", {26'd0, txn_len, spi_mode, s_addr}, fexp);
    rx_data_m = rx;
    busy_m = 1'b0;
    @(negedge sys_clk);
    chk("capture_fields", {26'd0, txn_len, spi_mode, s_addr}, fexp);
    chk("capture_data", tx_data_m, d);
    chk("capture_txn_en", 32'(txn_en), 0);
    @(negedge sys_clk);
  endtask

  task automatic pop_rsp(input logic [1:0] a, input logic [31:0] d, input logic e);
    chk("rsp_valid", 32'(rsp_valid), 1);
    chk("rsp_data", rsp_data, d);
    chk("rsp_addr", 32'(rsp_addr), 32'(a));
    chk("rsp_err", 32'(rsp_err), 32'(e));
    rsp_ready = 1'b1;
    @(negedge sys_clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    int n;
    logic saw;
    // ---- reset values ----
    #12;
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_txn_en", 32'(txn_en), 0);
    chk("rst_fields", {26'd0, txn_len, spi_mode, s_addr}, 0);
    chk("rst_tx_data", tx_data_m, 0);
    chk("rst_idle", 32'(idle), 1);
    @(negedge sys_clk); rst_n = 1'b1;
    @(negedge sys_clk);

    // ---- single transaction ----
    push_cmd(2'd2, 2'b01, 2'b00, 32'h0000A5C3);
    serve(2'd2, 2'b01, 2'b00, 32'h0000A5C3, 32'h00003C5A);
    pop_rsp(2'd2, 32'h00003C5A, 1'b0);
    @(negedge sys_clk);
    chk("idle_after_single", 32'(idle), 1);

    // ---- fill response FIFO with 4 responses ----
    for (int i = 0; i < 4; i++) push_cmd(2'(i), 2'b00, 2'b00, 32'h100 + i);
    for (int i = 0; i < 4; i++) serve(2'(i), 2'b00, 2'b00, 32'h100 + i, 32'h200 + i);

    // ---- command FIFO fills while sequencer is stalled ----
    for (int i = 0; i < 4; i++) push_cmd(2'(i), 2'(i), 2'(i), 32'hC0DE0000 + i);
    chk("cmd_full", 32'(cmd_ready), 0);
    cmd_valid = 1'b1; cmd_addr = 2'd3; cmd_data = 32'hBAD0BAD0;
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      chk("fifth_held", 32'(cmd_ready), 0);
      chk("stall_no_launch", 32'(txn_en), 0);
    end
    cmd_valid = 1'b0;

    // ---- each freed slot allows exactly one launch ----
    for (int i = 0; i < 4; i++) begin
      pop_rsp(2'(i), 32'h200 + i, 1'b0);
      serve(2'(i), 2'(i), 2'(i), 32'hC0DE0000 + i, 32'h300 + i);
      repeat (3) @(negedge sys_clk);
      chk("one_launch_per_slot", 32'(txn_en), 0);
    end
    for (int i = 0; i < 4; i++) pop_rsp(2'(i), 32'h300 + i, 1'b0);
    @(negedge sys_clk);
    chk("idle_after_stall", 32'(idle), 1);

    // ---- start timeout ----
    push_cmd(2'd1, 2'b10, 2'b11, 32'hDEADBEEF);
    n = 0;
    while (!txn_en && n < 20) begin @(negedge sys_clk); n++; end
    n = 0;
    while (txn_en && n < 200) begin n++; @(negedge sys_clk); end
    chk("timeout_len", 32'(n), START_TIMEOUT);
    pop_rsp(2'd1, 32'h0, 1'b1);
    push_cmd(2'd3, 2'b00, 2'b01, 32'h12345678);
    serve(2'd3, 2'b00, 2'b01, 32'h12345678, 32'h87654321);
    pop_rsp(2'd3, 32'h87654321, 1'b0);

    // ---- reset while ACTIVE with commands queued ----
    for (int i = 0; i < 4; i++) push_cmd(2'(i), 2'b11, 2'b10, 32'hF00 + i);
    n = 0;
    while (!txn_en && n < 20) begin @(negedge sys_clk); n++; end
    busy_m = 1'b1;
    @(negedge sys_clk);
    chk("pre_rst_active", 32'(txn_en), 0);
    @(posedge sys_clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_txn_en", 32'(txn_en), 0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 1);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
    chk("mid_rst_fields", {26'd0, txn_len, spi_mode, s_addr}, 0);
    chk("mid_rst_tx_data", tx_data_m, 0);
    chk("mid_rst_idle", 32'(idle), 1);
    busy_m = 1'b0;
    @(negedge sys_clk); rst_n = 1'b1;
    saw = 1'b0;
    repeat (80) begin
      @(negedge sys_clk);
      if (rsp_valid || txn_en) saw = 1'b1;
    end
    chk("no_activity_after_rst", 32'(saw), 0);
    chk("idle_after_rst", 32'(idle), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
